// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : demux_pkg
//  Purpose  : Shared constants and helpers for the 1-to-2 buffered demux.
//             DEF_WIDTH / DEF_DEPTH are the default word width and per-port
//             buffer depth; CNT_W is the width of the per-port transfer
//             counters, which saturate rather than wrap.
//  Revision : 1.0  initial release
// ============================================================================
package demux_pkg;

   localparam int DEF_WIDTH = 5;
   localparam int DEF_DEPTH = 2;
   localparam int CNT_W     = 8;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Saturating increment: holds at CNT_MAX instead of rolling over to 0.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
      return (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_2entry.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_2entry
//  Purpose  : DEPTH-entry synchronous FIFO with registered storage. The head
//             word is read straight from storage, so there is no
//             combinational path from wdata to head.
//  Ports    : clk, rst_n (async assert, active-low)
//             push, wdata       - write request; ignored when full
//             pop               - remove head; ignored when empty
//             full, empty, head - status and current head word
//  Revision : 1.0  initial release
// ============================================================================
module fifo_2entry
   import demux_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W = $clog2(DEPTH + 1);

   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             do_push;
   logic             do_pop;

   // Pointers wrap explicitly so non-power-of-two depths also work.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign full  = (occ_q == FULL_OCC);
   assign empty = (occ_q == '0);
   assign head  = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;

      // Storage is written only on a push, so a stale head stays stable.
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = ptr_next(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = ptr_next(rd_ptr_q);
      end

      case ({do_push, do_pop})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/demux_5bit_1to2.sv
`default_nettype none
// ============================================================================
//  Module   : demux_5bit_1to2
//  Purpose  : Buffered 1-to-2 demultiplexer. A word offered on data_in is
//             routed by sel into the port-1 (sel=0) or port-2 (sel=1) FIFO.
//             Each output port is a valid/ready interface with a saturating
//             count of completed transfers.
//  Ports    : clk, rst_n (async assert, active-low)
//             data_in, sel, in_valid, in_ready   - input handshake
//             data_out1/2, out_valid1/2,
//             out_ready1/2                       - output handshakes
//             xfer_cnt1/2                        - per-port transfer counts
//  Revision : 1.0  initial release
// ============================================================================
module demux_5bit_1to2
   import demux_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] data_out1,
   output logic [WIDTH-1:0] data_out2,
   output logic             out_valid1,
   output logic             out_valid2,
   input  logic             out_ready1,
   input  logic             out_ready2,
   output logic [CNT_W-1:0] xfer_cnt1,
   output logic [CNT_W-1:0] xfer_cnt2
);

   logic             full1, full2;
   logic             empty1, empty2;
   logic             accept;
   logic             push1, push2;
   logic             pop1, pop2;
   logic [CNT_W-1:0] xfer_cnt1_q, xfer_cnt1_d;
   logic [CNT_W-1:0] xfer_cnt2_q, xfer_cnt2_d;

   // Readiness reflects the addressed buffer only, so a full port never
   // blocks traffic headed to the other port. Full status is registered,
   // so a pop frees space for the next cycle, not the current one.
   assign in_ready   = sel ? !full2 : !full1;
   assign accept     = in_valid && in_ready;
   assign push1      = accept && !sel;
   assign push2      = accept && sel;

   assign out_valid1 = !empty1;
   assign out_valid2 = !empty2;
   assign pop1       = out_valid1 && out_ready1;
   assign pop2       = out_valid2 && out_ready2;

   assign xfer_cnt1  = xfer_cnt1_q;
   assign xfer_cnt2  = xfer_cnt2_q;

   always_comb begin
      xfer_cnt1_d = xfer_cnt1_q;
      xfer_cnt2_d = xfer_cnt2_q;
      if (pop1) begin
         xfer_cnt1_d = sat_inc(xfer_cnt1_q);
      end
      if (pop2) begin
         xfer_cnt2_d = sat_inc(xfer_cnt2_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xfer_cnt1_q <= '0;
         xfer_cnt2_q <= '0;
      end else begin
         xfer_cnt1_q <= xfer_cnt1_d;
         xfer_cnt2_q <= xfer_cnt2_d;
      end
   end

   fifo_2entry #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo1 (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push1),
      .wdata (data_in),
      .pop   (pop1),
      .full  (full1),
      .empty (empty1),
      .head  (data_out1)
   );

   fifo_2entry #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo2 (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push2),
      .wdata (data_in),
      .pop   (pop2),
      .full  (full2),
      .empty (empty2),
      .head  (data_out2)
   );

endmodule
`default_nettype wire

// File: tb/tb_demux_5bit_1to2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_5bit_1to2
//  Purpose  : Self-checking bench for demux_5bit_1to2. Directed scenarios
//             followed by random traffic compared against per-port queues.
//  Revision : 1.0  initial release
// ============================================================================
module tb_demux_5bit_1to2;

   localparam int W = 5;
   localparam int D = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] data_in;
   logic         sel;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] data_out1, data_out2;
   logic         out_valid1, out_valid2;
   logic         out_ready1, out_ready2;
   logic [7:0]   xfer_cnt1, xfer_cnt2;

   int n_vec = 0;
   int n_err = 0;
   int ec1   = 0;   // expected transfer counts since last reset
   int ec2   = 0;
   logic [W-1:0] mq1[$];
   logic [W-1:0] mq2[$];

   demux_5bit_1to2 #(.WIDTH(W), .DEPTH(D)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .sel        (sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .data_out1  (data_out1),
      .data_out2  (data_out2),
      .out_valid1 (out_valid1),
      .out_valid2 (out_valid2),
      .out_ready1 (out_ready1),
      .out_ready2 (out_ready2),
      .xfer_cnt1  (xfer_cnt1),
      .xfer_cnt2  (xfer_cnt2)
   );

   always #5 clk = ~clk;

   // One rising edge; returns on the following falling edge for sampling.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      in_valid   = 1'b0;
      out_ready1 = 1'b0;
      out_ready2 = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; sel = 1'b0; data_in = '0; idle();
      repeat (2) @(negedge clk);
      n_vec++; if (out_valid1 !== 1'b0 || out_valid2 !== 1'b0) begin n_err++;
         $display("FAIL rst_valid: got %b%b expected 00", out_valid1, out_valid2); end
      n_vec++; if (data_out1 !== 5'b00000 || data_out2 !== 5'b00000) begin n_err++;
         $display("FAIL rst_data: got %b/%b expected 00000/00000", data_out1, data_out2); end
      n_vec++; if (xfer_cnt1 !== 8'd0 || xfer_cnt2 !== 8'd0) begin n_err++;
         $display("FAIL rst_cnt: got %0d/%0d expected 0/0", xfer_cnt1, xfer_cnt2); end
      sel = 1'b1; #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++;
         $display("FAIL rst_ready: got %b expected 1", in_ready); end
      sel = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      n_vec++; if (out_valid1 !== 1'b0 || out_valid2 !== 1'b0 || in_ready !== 1'b1) begin n_err++;
         $display("FAIL rst_release: got v=%b%b rdy=%b expected v=00 rdy=1", out_valid1, out_valid2, in_ready); end
   endtask

   task automatic test_routing();
      in_valid = 1'b1; sel = 1'b0; data_in = 5'b11000;
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++;
         $display("FAIL route_ready: got %b expected 1", in_ready); end
      n_vec++; if (out_valid1 !== 1'b0) begin n_err++;
         $display("FAIL route_latency: got %b expected 0", out_valid1); end
      tick();
      n_vec++; if (out_valid1 !== 1'b1 || data_out1 !== 5'b11000 || out_valid2 !== 1'b0) begin n_err++;
         $display("FAIL route_p1: got v1=%b d1=%b v2=%b expected v1=1 d1=11000 v2=0", out_valid1, data_out1, out_valid2); end
      sel = 1'b1; data_in = 5'b01110;
      tick();
      in_valid = 1'b0;
      n_vec++; if (out_valid2 !== 1'b1 || data_out2 !== 5'b01110) begin n_err++;
         $display("FAIL route_p2: got v2=%b d2=%b expected v2=1 d2=01110", out_valid2, data_out2); end
      n_vec++; if (data_out1 !== 5'b11000) begin n_err++;
         $display("FAIL route_p1_hold: got %b expected 11000", data_out1); end
      out_ready1 = 1'b1; out_ready2 = 1'b1;
      tick();
      idle(); ec1 = 1; ec2 = 1;
      n_vec++; if (out_valid1 !== 1'b0 || out_valid2 !== 1'b0 || xfer_cnt1 !== 8'd1 || xfer_cnt2 !== 8'd1) begin n_err++;
         $display("FAIL route_drain: got v=%b%b cnt=%0d/%0d expected v=00 cnt=1/1", out_valid1, out_valid2, xfer_cnt1, xfer_cnt2); end
   endtask

   task automatic test_full_order();
      in_valid = 1'b1; sel = 1'b0; data_in = 5'b00001; tick();
      data_in = 5'b00010; tick();
      data_in = 5'b00011; #1;
      n_vec++; if (in_ready !== 1'b0) begin n_err++;
         $display("FAIL full_ready0: got %b expected 0", in_ready); end
      sel = 1'b1; data_in = 5'b00111; #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++;
         $display("FAIL full_indep_ready: got %b expected 1", in_ready); end
      tick();
      n_vec++; if (out_valid2 !== 1'b1 || data_out2 !== 5'b00111 || data_out1 !== 5'b00001) begin n_err++;
         $display("FAIL full_indep_push: got v2=%b d2=%b d1=%b expected v2=1 d2=00111 d1=00001", out_valid2, data_out2, data_out1); end
      // Pop while still offering a word to the full port: it must not be taken.
      sel = 1'b0; data_in = 5'b00011; out_ready1 = 1'b1; #1;
      n_vec++; if (in_ready !== 1'b0) begin n_err++;
         $display("FAIL full_same_cycle: got %b expected 0", in_ready); end
      tick();
      in_valid = 1'b0; #1;
      n_vec++; if (out_valid1 !== 1'b1 || data_out1 !== 5'b00010) begin n_err++;
         $display("FAIL full_order2: got v1=%b d1=%b expected v1=1 d1=00010", out_valid1, data_out1); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++;
         $display("FAIL full_ready_next: got %b expected 1", in_ready); end
      tick();
      n_vec++; if (out_valid1 !== 1'b0 || xfer_cnt1 !== 8'd3) begin n_err++;
         $display("FAIL full_empty: got v1=%b cnt1=%0d expected v1=0 cnt1=3", out_valid1, xfer_cnt1); end
      out_ready1 = 1'b0; out_ready2 = 1'b1;
      tick();
      idle(); ec1 = 3; ec2 = 2;
      n_vec++; if (out_valid2 !== 1'b0 || xfer_cnt2 !== 8'd2) begin n_err++;
         $display("FAIL full_p2_drain: got v2=%b cnt2=%0d expected v2=0 cnt2=2", out_valid2, xfer_cnt2); end
   endtask

   task automatic test_simultaneous();
      in_valid = 1'b1; sel = 1'b1; data_in = 5'b01010; tick();
      n_vec++; if (data_out2 !== 5'b01010) begin n_err++;
         $display("FAIL simul_head: got %b expected 01010", data_out2); end
      data_in = 5'b11110; out_ready2 = 1'b1; tick();
      idle();
      n_vec++; if (out_valid2 !== 1'b1 || data_out2 !== 5'b11110 || xfer_cnt2 !== 8'd3) begin n_err++;
         $display("FAIL simul_swap: got v2=%b d2=%b cnt2=%0d expected v2=1 d2=11110 cnt2=3", out_valid2, data_out2, xfer_cnt2); end
      // A single pop must empty the port, proving occupancy stayed at 1.
      out_ready2 = 1'b1; tick(); idle(); ec2 = 4;
      n_vec++; if (out_valid2 !== 1'b0 || xfer_cnt2 !== 8'd4) begin n_err++;
         $display("FAIL simul_occ1: got v2=%b cnt2=%0d expected v2=0 cnt2=4", out_valid2, xfer_cnt2); end
      // Pop request on an empty port changes nothing.
      out_ready1 = 1'b1; out_ready2 = 1'b1; tick(); idle();
      n_vec++; if (xfer_cnt1 !== 8'd3 || xfer_cnt2 !== 8'd4 || out_valid1 !== 1'b0) begin n_err++;
         $display("FAIL empty_pop: got cnt=%0d/%0d expected 3/4", xfer_cnt1, xfer_cnt2); end
   endtask

   task automatic test_saturation();
      logic [W-1:0] w;
      for (int i = 0; i < 300; i++) begin
         w = W'(i);
         in_valid = 1'b1; sel = 1'b0; data_in = w; out_ready1 = 1'b0;
         tick();
         in_valid = 1'b0; out_ready1 = 1'b1;
         n_vec++; if (data_out1 !== w) begin n_err++;
            $display("FAIL sat_data[%0d]: got %b expected %b", i, data_out1, w); end
         tick();
         ec1 = (ec1 < 255) ? ec1 + 1 : 255;
         n_vec++; if (xfer_cnt1 !== 8'(ec1)) begin n_err++;
            $display("FAIL sat_cnt1[%0d]: got %0d expected %0d", i, xfer_cnt1, ec1); end
      end
      idle();
      n_vec++; if (xfer_cnt1 !== 8'd255 || xfer_cnt2 !== 8'd4) begin n_err++;
         $display("FAIL sat_final: got %0d/%0d expected 255/4", xfer_cnt1, xfer_cnt2); end
   endtask

   task automatic test_reset_mid_traffic();
      in_valid = 1'b1; sel = 1'b0; data_in = 5'b10101; tick();
      data_in = 5'b10110; tick();
      sel = 1'b1; data_in = 5'b01011; tick();
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if (out_valid1 !== 1'b0 || out_valid2 !== 1'b0 || data_out1 !== 5'b00000 || data_out2 !== 5'b00000) begin n_err++;
         $display("FAIL midrst_out: got v=%b%b d=%b/%b expected v=00 d=00000/00000", out_valid1, out_valid2, data_out1, data_out2); end
      n_vec++; if (xfer_cnt1 !== 8'd0 || xfer_cnt2 !== 8'd0 || in_ready !== 1'b1) begin n_err++;
         $display("FAIL midrst_cnt: got cnt=%0d/%0d rdy=%b expected 0/0 rdy=1", xfer_cnt1, xfer_cnt2, in_ready); end
      @(negedge clk);
      // Release with a word offered: it is accepted on the very next edge.
      rst_n = 1'b1; sel = 1'b0; data_in = 5'b10011; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_vec++; if (out_valid1 !== 1'b1 || data_out1 !== 5'b10011 || out_valid2 !== 1'b0) begin n_err++;
         $display("FAIL midrst_first: got v1=%b d1=%b v2=%b expected v1=1 d1=10011 v2=0", out_valid1, data_out1, out_valid2); end
      out_ready1 = 1'b1; tick(); idle();
      n_vec++; if (out_valid1 !== 1'b0 || xfer_cnt1 !== 8'd1) begin n_err++;
         $display("FAIL midrst_stale: got v1=%b cnt1=%0d expected v1=0 cnt1=1", out_valid1, xfer_cnt1); end
      ec1 = 1; ec2 = 0;
      mq1.delete(); mq2.delete();
   endtask

   task automatic test_random();
      logic exp_rdy, acc, p1, p2, s;
      logic [W-1:0] d;
      for (int c = 0; c < 400; c++) begin
         in_valid   = ($urandom_range(0, 3) != 0);
         sel        = 1'($urandom_range(0, 1));
         data_in    = W'($urandom);
         out_ready1 = ($urandom_range(0, 2) == 0);
         out_ready2 = ($urandom_range(0, 2) == 0);
         #1;
         exp_rdy = sel ? (mq2.size() < D) : (mq1.size() < D);
         n_vec++; if (in_ready !== exp_rdy) begin n_err++;
            $display("FAIL rand_ready[%0d]: got %b expected %b", c, in_ready, exp_rdy); end
         acc = in_valid && exp_rdy;
         p1  = out_ready1 && (mq1.size() > 0);
         p2  = out_ready2 && (mq2.size() > 0);
         s   = sel;
         d   = data_in;
         tick();
         if (p1) begin void'(mq1.pop_front()); ec1 = (ec1 < 255) ? ec1 + 1 : 255; end
         if (p2) begin void'(mq2.pop_front()); ec2 = (ec2 < 255) ? ec2 + 1 : 255; end
         if (acc) begin
            if (s) mq2.push_back(d);
            else   mq1.push_back(d);
         end
         n_vec++; if (out_valid1 !== (mq1.size() != 0) || out_valid2 !== (mq2.size() != 0)) begin n_err++;
            $display("FAIL rand_valid[%0d]: got %b%b expected %b%b", c, out_valid1, out_valid2, mq1.size() != 0, mq2.size() != 0); end
         if (mq1.size() != 0) begin
            n_vec++; if (data_out1 !== mq1[0]) begin n_err++;
               $display("FAIL rand_d1[%0d]: got %b expected %b", c, data_out1, mq1[0]); end
         end
         if (mq2.size() != 0) begin
            n_vec++; if (data_out2 !== mq2[0]) begin n_err++;
               $display("FAIL rand_d2[%0d]: got %b expected %b", c, data_out2, mq2[0]); end
         end
         n_vec++; if (xfer_cnt1 !== 8'(ec1) || xfer_cnt2 !== 8'(ec2)) begin n_err++;
            $display("FAIL rand_cnt[%0d]: got %0d/%0d expected %0d/%0d", c, xfer_cnt1, xfer_cnt2, ec1, ec2); end
      end
      // Drain whatever the model still holds.
      in_valid = 1'b0; out_ready1 = 1'b1; out_ready2 = 1'b1;
      repeat (D) begin
         if (mq1.size() != 0) begin void'(mq1.pop_front()); ec1 = (ec1 < 255) ? ec1 + 1 : 255; end
         if (mq2.size() != 0) begin void'(mq2.pop_front()); ec2 = (ec2 < 255) ? ec2 + 1 : 255; end
         tick();
      end
      idle();
      n_vec++; if (out_valid1 !== 1'b0 || out_valid2 !== 1'b0 || xfer_cnt1 !== 8'(ec1) || xfer_cnt2 !== 8'(ec2)) begin n_err++;
         $display("FAIL rand_drain: got v=%b%b cnt=%0d/%0d expected v=00 cnt=%0d/%0d", out_valid1, out_valid2, xfer_cnt1, xfer_cnt2, ec1, ec2); end
   endtask

   initial begin
      test_reset();
      test_routing();
      test_full_order();
      test_simultaneous();
      test_saturation();
      test_reset_mid_traffic();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
